// File: rtl/dalu_mc.sv
`default_nettype none
// ============================================================================
// Module   : dalu_mc
// Purpose  : Multi-cycle ALU. Single-cycle arithmetic and logic ops, plus an
//            iterative shift-add multiplier and an optional restoring divider.
//            The divider and DIV/DIVH opcodes exist only when DALU_MC_DIV_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
module dalu_mc #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [7:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cf,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] acc,
    output logic [W-1:0] c,
    output logic         c_flag,
    output logic         z_flag,
    output logic         o_flag,
    output logic         err
);

    localparam int H  = W / 2;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] c_LAST = CW'(W - 1);

    localparam logic [7:0] c_OP_ADD  = 8'h01;
    localparam logic [7:0] c_OP_ADC  = 8'h02;
    localparam logic [7:0] c_OP_SUB  = 8'h03;
    localparam logic [7:0] c_OP_SUC  = 8'h04;
    localparam logic [7:0] c_OP_MULH = 8'h05;
    localparam logic [7:0] c_OP_MUL  = 8'h06;
`ifdef DALU_MC_DIV_EN
    localparam logic [7:0] c_OP_DIVH = 8'h07;
    localparam logic [7:0] c_OP_DIV  = 8'h08;
`endif
    localparam logic [7:0] c_OP_CMP  = 8'h09;
    localparam logic [7:0] c_OP_AND  = 8'h0A;
    localparam logic [7:0] c_OP_NEG  = 8'h0B;
    localparam logic [7:0] c_OP_NOT  = 8'h0C;
    localparam logic [7:0] c_OP_OR   = 8'h0D;
    localparam logic [7:0] c_OP_SHL  = 8'h0E;
    localparam logic [7:0] c_OP_SHR  = 8'h0F;
    localparam logic [7:0] c_OP_XOR  = 8'h10;
    localparam logic [7:0] c_OP_TEST = 8'h11;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_MUL  = 2'd1;
`ifdef DALU_MC_DIV_EN
    localparam logic [1:0] c_S_DIV  = 2'd2;
`endif

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_hi;
    logic [W-1:0]  r_lo;
    logic [W-1:0]  r_opnd;
    logic          r_half;

    logic          w_accept;
    logic          w_last;
    logic [W-1:0]  w_a_lo;
    logic [W-1:0]  w_b_lo;
    logic [W:0]    w_sa;
    logic [W:0]    w_sb;
    logic [W:0]    w_sum;

    logic          w_ld_acc;
    logic          w_ld_c;
    logic          w_ld_co;
    logic          w_ld_z;
    logic [W-1:0]  w_acc_v;
    logic [W-1:0]  w_c_v;
    logic          w_cf_v;
    logic          w_zf_v;
    logic          w_of_v;
    logic          w_err_v;
    logic          w_go_mul;
    logic          w_half;

    logic [W:0]    w_msum;
    logic [W-1:0]  w_mhi;
    logic [W-1:0]  w_mlo;

`ifdef DALU_MC_DIV_EN
    logic          w_go_div;
    logic [W:0]    w_dt;
    logic          w_dge;
    logic [W-1:0]  w_dhi;
    logic [W-1:0]  w_dlo;
`endif

    assign busy     = (r_state != c_S_IDLE);
    assign w_accept = start && !busy;
    assign w_last   = (r_cnt == c_LAST);
    assign w_a_lo   = {{(W-H){1'b0}}, a[H-1:0]};
    assign w_b_lo   = {{(W-H){1'b0}}, b[H-1:0]};
    assign w_sa     = {a[W-1], a};
    assign w_sb     = {b[W-1], b};

    // One shift-add step: add multiplicand into the high half, shift {hi,lo} right.
    assign w_msum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : {W{1'b0}})};
    assign w_mhi  = w_msum[W:1];
    assign w_mlo  = {w_msum[0], r_lo[W-1:1]};

`ifdef DALU_MC_DIV_EN
    // One restoring step: the partial remainder never exceeds 2*divisor-1.
    assign w_dt  = {r_hi, r_lo[W-1]};
    assign w_dge = (w_dt >= {1'b0, r_opnd});
    assign w_dhi = w_dge ? (w_dt[W-1:0] - r_opnd) : w_dt[W-1:0];
    assign w_dlo = {r_lo[W-2:0], w_dge};
`endif

    always_comb begin
        w_ld_acc = 1'b0;
        w_ld_c   = 1'b0;
        w_ld_co  = 1'b0;
        w_ld_z   = 1'b0;
        w_acc_v  = acc;
        w_c_v    = c;
        w_cf_v   = 1'b0;
        w_zf_v   = 1'b0;
        w_of_v   = 1'b0;
        w_err_v  = 1'b0;
        w_go_mul = 1'b0;
        w_half   = 1'b0;
        w_sum    = '0;
`ifdef DALU_MC_DIV_EN
        w_go_div = 1'b0;
`endif
        case (op)
            c_OP_ADD, c_OP_ADC, c_OP_SUB, c_OP_SUC: begin
                case (op)
                    c_OP_ADD: w_sum = w_sa + w_sb;
                    c_OP_ADC: w_sum = w_sa + w_sb + {{W{1'b0}}, cf};
                    c_OP_SUB: w_sum = w_sa - w_sb;
                    default:  w_sum = w_sa - w_sb - {{W{1'b0}}, cf};
                endcase
                w_ld_acc = 1'b1;
                w_acc_v  = w_sum[W-1:0];
                w_ld_co  = 1'b1;
                w_cf_v   = w_sum[W];
                w_of_v   = w_sum[W] ^ w_sum[W-1];
                w_ld_z   = 1'b1;
                w_zf_v   = (w_sum[W-1:0] == '0);
            end
            c_OP_MULH: begin
                w_go_mul = 1'b1;
                w_half   = 1'b1;
            end
            c_OP_MUL: w_go_mul = 1'b1;
`ifdef DALU_MC_DIV_EN
            c_OP_DIVH, c_OP_DIV: begin
                w_half = (op == c_OP_DIVH);
                if ((op == c_OP_DIVH) ? (b[H-1:0] == '0) : (b == '0)) begin
                    w_ld_acc = 1'b1;
                    w_acc_v  = '1;
                    w_ld_c   = 1'b1;
                    w_c_v    = a;
                    w_ld_co  = 1'b1;
                    w_ld_z   = 1'b1;
                    w_err_v  = 1'b1;
                end else begin
                    w_go_div = 1'b1;
                end
            end
`endif
            c_OP_CMP: begin
                w_ld_co = 1'b1;
                w_ld_z  = 1'b1;
                w_zf_v  = (a == b);
                w_cf_v  = (a < b);
                w_of_v  = (a > b);
            end
            c_OP_AND, c_OP_NEG, c_OP_NOT, c_OP_OR, c_OP_XOR: begin
                case (op)
                    c_OP_AND: w_acc_v = a & b;
                    c_OP_NEG: w_acc_v = ~a;
                    c_OP_NOT: w_acc_v = (a == '0) ? {{(W-1){1'b0}}, 1'b1} : '0;
                    c_OP_OR:  w_acc_v = a | b;
                    default:  w_acc_v = a ^ b;
                endcase
                w_ld_acc = 1'b1;
                w_ld_co  = 1'b1;
                w_ld_z   = 1'b1;
                w_zf_v   = (w_acc_v == '0);
            end
            c_OP_SHL, c_OP_SHR: begin
                w_acc_v  = (op == c_OP_SHL) ? {a[W-2:0], 1'b0} : {1'b0, a[W-1:1]};
                w_cf_v   = (op == c_OP_SHL) ? a[W-1] : a[0];
                w_ld_acc = 1'b1;
                w_ld_co  = 1'b1;
                w_ld_z   = 1'b1;
                w_zf_v   = (w_acc_v == '0);
            end
            c_OP_TEST: begin
                w_ld_z = 1'b1;
                w_zf_v = ((a & b) == '0);
            end
            default: w_err_v = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept && w_go_mul) w_state_nxt = c_S_MUL;
`ifdef DALU_MC_DIV_EN
                else if (w_accept && w_go_div) w_state_nxt = c_S_DIV;
`endif
            end
            c_S_MUL: if (w_last) w_state_nxt = c_S_IDLE;
`ifdef DALU_MC_DIV_EN
            c_S_DIV: if (w_last) w_state_nxt = c_S_IDLE;
`endif
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done   <= 1'b0;
            acc    <= '0;
            c      <= '0;
            c_flag <= 1'b0;
            z_flag <= 1'b0;
            o_flag <= 1'b0;
            err    <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_opnd <= '0;
            r_half <= 1'b0;
            r_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                r_half <= w_half;
                r_cnt  <= '0;
                if (w_go_mul) begin
                    r_hi   <= '0;
                    r_lo   <= w_half ? w_b_lo : b;
                    r_opnd <= w_half ? w_a_lo : a;
                end
`ifdef DALU_MC_DIV_EN
                else if (w_go_div) begin
                    r_hi   <= '0;
                    r_lo   <= w_half ? w_a_lo : a;
                    r_opnd <= w_half ? w_b_lo : b;
                end
`endif
                else begin
                    done <= 1'b1;
                    err  <= w_err_v;
                    if (w_ld_acc) acc <= w_acc_v;
                    if (w_ld_c)   c   <= w_c_v;
                    if (w_ld_z)   z_flag <= w_zf_v;
                    if (w_ld_co) begin
                        c_flag <= w_cf_v;
                        o_flag <= w_of_v;
                    end
                end
            end else if (r_state == c_S_MUL) begin
                r_hi  <= w_mhi;
                r_lo  <= w_mlo;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    done   <= 1'b1;
                    acc    <= w_mlo;
                    c      <= r_half ? '0 : w_mhi;
                    z_flag <= (w_mlo == '0);
                    c_flag <= 1'b0;
                    o_flag <= 1'b0;
                    err    <= 1'b0;
                end
            end
`ifdef DALU_MC_DIV_EN
            else if (r_state == c_S_DIV) begin
                r_hi  <= w_dhi;
                r_lo  <= w_dlo;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    done   <= 1'b1;
                    acc    <= w_dlo;
                    c      <= w_dhi;
                    z_flag <= (w_dlo == '0);
                    c_flag <= 1'b0;
                    o_flag <= 1'b0;
                    err    <= 1'b0;
                end
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dalu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_dalu_mc
// Purpose  : Self-checking bench for dalu_mc: directed vector table, hand
//            sequences for back-to-back/abort cases, and a random phase
//            checked against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dalu_mc;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cf = 1'b0;
    logic         busy, done, c_flag, z_flag, o_flag, err;
    logic [W-1:0] acc, c;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] m_acc, m_c;
    logic         m_cf, m_zf, m_of, m_err;

    typedef struct {
        logic [7:0]   op;
        logic [W-1:0] a, b;
        logic         ci;
        logic [5:0]   msk;   // {err, of, zf, cf, c, acc}
        logic [W-1:0] eacc, ec;
        logic         ecf, ezf, eof, eerr;
        int           lat;
    } vec_t;

    vec_t vq[$];

    dalu_mc #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cf(cf),
        .busy(busy), .done(done), .acc(acc), .c(c),
        .c_flag(c_flag), .z_flag(z_flag), .o_flag(o_flag), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [7:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic ci, input logic [5:0] msk, input logic [W-1:0] eacc,
                                input logic [W-1:0] ec, input logic ecf, input logic ezf,
                                input logic eof, input logic eerr, input int lat);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.ci = ci; v.msk = msk;
        v.eacc = eacc; v.ec = ec; v.ecf = ecf; v.ezf = ezf; v.eof = eof; v.eerr = eerr;
        v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one op, then wait (bounded) for done; returns at the done cycle.
    task automatic run_op(input logic [7:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, output int nb, output bit gd);
        @(negedge clk);
        chk("done_pulse_width", 32'(done), 32'd0);
        op = o; a = x; b = y; cf = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 8'($urandom); a = 16'($urandom); b = 16'($urandom); cf = 1'($urandom);
        nb = 0;
        gd = 1'b0;
        for (int k = 0; k < W + 4 && !gd; k++) begin
            if (done) gd = 1'b1;
            else begin
                if (busy) nb++;
                @(negedge clk);
            end
        end
        if (!gd) chk("done_timeout", 32'(gd), 32'd1);
    endtask

    task automatic model_reset();
        m_acc = '0; m_c = '0; m_cf = 1'b0; m_zf = 1'b0; m_of = 1'b0; m_err = 1'b0;
    endtask

    // Reference behaviour written from the opcode rules with plain integer arithmetic.
    task automatic model_op(input logic [7:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic ci, output int lat);
        int sx, sy, r;
        logic [W:0] s;
        longint p;
        logic [W-1:0] xh, yh;
        sx = int'($signed(x));
        sy = int'($signed(y));
        xh = x % 16'd256;
        yh = y % 16'd256;
        lat = 0;
        case (o)
            8'h01, 8'h02, 8'h03, 8'h04: begin
                if (o == 8'h01)      r = sx + sy;
                else if (o == 8'h02) r = sx + sy + int'(ci);
                else if (o == 8'h03) r = sx - sy;
                else                 r = sx - sy - int'(ci);
                s = r[W:0];
                m_acc = s[W-1:0]; m_cf = s[W]; m_of = s[W] ^ s[W-1];
                m_zf = (m_acc == 0); m_err = 1'b0;
            end
            8'h05, 8'h06: begin
                p = (o == 8'h06) ? longint'(x) * longint'(y) : longint'(xh) * longint'(yh);
                m_acc = p[W-1:0]; m_c = p[2*W-1:W];
                m_zf = (m_acc == 0); m_cf = 1'b0; m_of = 1'b0; m_err = 1'b0;
                lat = W;
            end
`ifdef DALU_MC_DIV_EN
            8'h07, 8'h08: begin
                if ((o == 8'h08 && y == 0) || (o == 8'h07 && yh == 0)) begin
                    m_acc = 16'hFFFF; m_c = x; m_err = 1'b1;
                end else begin
                    m_acc = (o == 8'h08) ? x / y : xh / yh;
                    m_c   = (o == 8'h08) ? x % y : xh % yh;
                    m_err = 1'b0;
                    lat = W;
                end
                m_zf = (m_err) ? 1'b0 : (m_acc == 0); m_cf = 1'b0; m_of = 1'b0;
            end
`endif
            8'h09: begin
                m_zf = (x == y); m_cf = (x < y); m_of = (x > y); m_err = 1'b0;
            end
            8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h10, 8'h0E, 8'h0F: begin
                m_cf = 1'b0;
                case (o)
                    8'h0A: m_acc = x & y;
                    8'h0B: m_acc = ~x;
                    8'h0C: m_acc = (x == 0) ? 16'd1 : 16'd0;
                    8'h0D: m_acc = x | y;
                    8'h10: m_acc = x ^ y;
                    8'h0E: begin m_acc = 16'(x * 2); m_cf = (x >= 16'h8000); end
                    default: begin m_acc = x / 2; m_cf = x[0]; end
                endcase
                m_zf = (m_acc == 0); m_of = 1'b0; m_err = 1'b0;
            end
            8'h11: begin m_zf = ((x & y) == 0); m_err = 1'b0; end
            default: m_err = 1'b1;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1; op = 8'h06; a = 16'hFFFF; b = 16'hFFFF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
        chk("rst_c", 32'(c), 32'd0);
        chk("rst_flags", 32'({c_flag, z_flag, o_flag, err}), 32'd0);
        @(negedge clk);
        chk("rst_start_ignored", 32'({busy, done}), 32'd0);
        model_reset();
    endtask

    initial begin
        int nb, lat;
        bit gd, seen;
        logic [7:0] o;
        logic [W-1:0] x, y;
        logic ci;

        vq.push_back(mk(8'h01, 16'h7FFF, 16'h0001, 0, 6'b111101, 16'h8000, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(8'h02, 16'hFFFF, 16'h0001, 1, 6'b111101, 16'h0001, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(8'h03, 16'h0005, 16'h0005, 0, 6'b111101, 16'h0000, 0, 0, 1, 0, 0, 0));
        vq.push_back(mk(8'h04, 16'h0000, 16'h0000, 1, 6'b111101, 16'hFFFF, 0, 1, 0, 0, 0, 0));
        vq.push_back(mk(8'h03, 16'h8000, 16'h0001, 0, 6'b111101, 16'h7FFF, 0, 1, 0, 1, 0, 0));
        vq.push_back(mk(8'h06, 16'hFFFF, 16'hFFFF, 0, 6'b111111, 16'h0001, 16'hFFFE, 0, 0, 0, 0, W));
        vq.push_back(mk(8'h05, 16'h12FF, 16'h34FF, 0, 6'b111111, 16'hFE01, 16'h0000, 0, 0, 0, 0, W));
        vq.push_back(mk(8'h05, 16'h1200, 16'h34FF, 0, 6'b111111, 16'h0000, 16'h0000, 0, 1, 0, 0, W));
        vq.push_back(mk(8'h09, 16'h0003, 16'h0005, 0, 6'b111111, 16'h0000, 16'h0000, 1, 0, 0, 0, 0));
        vq.push_back(mk(8'h09, 16'h0009, 16'h0009, 0, 6'b111100, 0, 0, 0, 1, 0, 0, 0));
        vq.push_back(mk(8'h09, 16'hFFFF, 16'h0001, 0, 6'b111100, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(8'h0E, 16'h8001, 16'h0000, 0, 6'b111101, 16'h0002, 0, 1, 0, 0, 0, 0));
        vq.push_back(mk(8'h0F, 16'h0001, 16'h0000, 0, 6'b111101, 16'h0000, 0, 1, 1, 0, 0, 0));
        vq.push_back(mk(8'h0C, 16'h0000, 16'h0000, 0, 6'b111101, 16'h0001, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(8'h0C, 16'h0005, 16'h0000, 0, 6'b111101, 16'h0000, 0, 0, 1, 0, 0, 0));
        vq.push_back(mk(8'h0B, 16'h00FF, 16'h0000, 0, 6'b111101, 16'hFF00, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(8'h0A, 16'hF0F0, 16'h0F0F, 0, 6'b111101, 16'h0000, 0, 0, 1, 0, 0, 0));
        vq.push_back(mk(8'h0D, 16'h1200, 16'h0034, 0, 6'b111101, 16'h1234, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(8'h20, 16'h5555, 16'h5555, 0, 6'b111111, 16'h1234, 16'h0000, 0, 0, 0, 1, 0));
        vq.push_back(mk(8'h10, 16'hA5A5, 16'hA5A5, 0, 6'b111101, 16'h0000, 0, 0, 1, 0, 0, 0));
        vq.push_back(mk(8'h11, 16'h0001, 16'h0002, 0, 6'b101001, 16'h0000, 0, 0, 1, 0, 0, 0));
        vq.push_back(mk(8'h11, 16'h0003, 16'h0002, 0, 6'b101001, 16'h0000, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(8'h00, 16'h0003, 16'h0002, 0, 6'b100011, 16'h0000, 16'h0000, 0, 0, 0, 1, 0));
`ifdef DALU_MC_DIV_EN
        vq.push_back(mk(8'h08, 16'h0064, 16'h0007, 0, 6'b111111, 16'h000E, 16'h0002, 0, 0, 0, 0, W));
        vq.push_back(mk(8'h08, 16'h0064, 16'h0000, 0, 6'b111111, 16'hFFFF, 16'h0064, 0, 0, 0, 1, 0));
        vq.push_back(mk(8'h07, 16'h1264, 16'h3407, 0, 6'b111111, 16'h000E, 16'h0002, 0, 0, 0, 0, W));
        vq.push_back(mk(8'h07, 16'h0064, 16'h1200, 0, 6'b111111, 16'hFFFF, 16'h0064, 0, 0, 0, 1, 0));
`else
        vq.push_back(mk(8'h08, 16'h0064, 16'h0007, 0, 6'b100011, 16'h0000, 16'h0000, 0, 0, 0, 1, 0));
        vq.push_back(mk(8'h07, 16'h0064, 16'h0007, 0, 6'b100011, 16'h0000, 16'h0000, 0, 0, 0, 1, 0));
`endif

        do_reset();

        foreach (vq[i]) begin
            run_op(vq[i].op, vq[i].a, vq[i].b, vq[i].ci, nb, gd);
            chk($sformatf("vec%0d_done", i), 32'(gd), 32'd1);
            chk($sformatf("vec%0d_busy_cycles", i), 32'(nb), 32'(vq[i].lat));
            if (vq[i].msk[0]) chk($sformatf("vec%0d_acc", i), 32'(acc), 32'(vq[i].eacc));
            if (vq[i].msk[1]) chk($sformatf("vec%0d_c", i), 32'(c), 32'(vq[i].ec));
            if (vq[i].msk[2]) chk($sformatf("vec%0d_cflag", i), 32'(c_flag), 32'(vq[i].ecf));
            if (vq[i].msk[3]) chk($sformatf("vec%0d_zflag", i), 32'(z_flag), 32'(vq[i].ezf));
            if (vq[i].msk[4]) chk($sformatf("vec%0d_oflag", i), 32'(o_flag), 32'(vq[i].eof));
            if (vq[i].msk[5]) chk($sformatf("vec%0d_err", i), 32'(err), 32'(vq[i].eerr));
        end

        // Back-to-back: a new request lands in the MUL done cycle.
        run_op(8'h06, 16'hFFFF, 16'hFFFF, 1'b0, nb, gd);
        chk("b2b_mul_busy_cycles", 32'(nb), 32'(W));
        chk("b2b_mul_acc", 32'(acc), 32'h0001);
        chk("b2b_mul_c", 32'(c), 32'hFFFE);
        op = 8'h02; a = 16'h0001; b = 16'h0001; cf = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_adc_done", 32'(done), 32'd1);
        chk("b2b_adc_acc", 32'(acc), 32'h0003);
        chk("b2b_adc_busy", 32'(busy), 32'd0);

        // Reset in the middle of a multiply aborts it without a done pulse.
        @(negedge clk);
        op = 8'h06; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_acc", 32'(acc), 32'd0);
        chk("abort_c", 32'(c), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        run_op(8'h01, 16'h7FFF, 16'h0001, 1'b0, nb, gd);
        chk("post_abort_add_done", 32'(gd), 32'd1);
        chk("post_abort_add_acc", 32'(acc), 32'h8000);
        chk("post_abort_add_oflag", 32'(o_flag), 32'd1);

        // Random phase against the reference model.
        do_reset();
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0: o = 8'($urandom_range(18, 255));
                1: o = 8'h00;
                default: o = 8'($urandom_range(1, 17));
            endcase
            x = 16'($urandom);
            case ($urandom_range(0, 7))
                0: y = 16'h0000;
                1: y = 16'($urandom) & 16'hFF00;
                2: y = x;
                default: y = 16'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) x = 16'h0000;
            ci = 1'($urandom);
            model_op(o, x, y, ci, lat);
            run_op(o, x, y, ci, nb, gd);
            chk($sformatf("rnd%0d_op%0h_done", n, o), 32'(gd), 32'd1);
            chk($sformatf("rnd%0d_op%0h_busy_cycles", n, o), 32'(nb), 32'(lat));
            chk($sformatf("rnd%0d_op%0h_acc", n, o), 32'(acc), 32'(m_acc));
            chk($sformatf("rnd%0d_op%0h_c", n, o), 32'(c), 32'(m_c));
            chk($sformatf("rnd%0d_op%0h_flags_czo", n, o), 32'({c_flag, z_flag, o_flag}),
                32'({m_cf, m_zf, m_of}));
            chk($sformatf("rnd%0d_op%0h_err", n, o), 32'(err), 32'(m_err));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dalu_mc.md
DALU_MC -- requirements
Module: dalu_mc

Interface
REQ-001 Parameter W, default 16: operand/result width; even, >=4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request; accepted on a clk edge where start=1 and busy=0.
REQ-005 op  input  8  opcode: 01 ADD, 02 ADC, 03 SUB, 04 SUC, 05 MULH, 06 MUL, 07 DIVH, 08 DIV, 09 CMP, 0A AND, 0B NEG, 0C NOT, 0D OR, 0E SHL, 0F SHR, 10 XOR, 11 TEST.
REQ-006 a, b  input  W  operands.
REQ-007 cf  input  1  carry-in for ADC/SUC.
REQ-008 busy  output  1  iterative op in progress; start ignored.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 acc  output  W  primary result (low product, quotient).
REQ-011 c  output  W  secondary result (high product, remainder).
REQ-012 c_flag, z_flag, o_flag  output  1 each  carry, zero, overflow/greater flags.
REQ-013 err  output  1  illegal opcode or divide-by-zero on last completed op.

Function
REQ-014 op, a, b, cf SHALL be latched at the accept edge; later input changes SHALL not affect the operation.
REQ-015 FSM states IDLE, MUL, DIV; IDLE->MUL on accepted MUL/MULH, IDLE->DIV on accepted DIV/DIVH with b!=0 (half-width divisor nonzero for DIVH), iterative state->IDLE after final iteration.
REQ-016 Single-cycle ops SHALL update results at the accept edge; done=1 the following cycle; busy stays 0.
REQ-017 MUL/MULH/DIV/DIVH SHALL run W iterations (shift-add multiply, restoring divide); busy=1 for exactly W cycles after accept; results and done=1 in the cycle busy falls.
REQ-018 start during done cycle SHALL be accepted (back-to-back, no bubble).
REQ-019 ADD/ADC/SUB/SUC: {c_flag,acc} = sign-extended (W+1)-bit a op b (op cf); o_flag = c_flag ^ acc[W-1]; z_flag = (acc==0); c unchanged.
REQ-020 MUL: {c,acc} = unsigned a*b (2W bits). MULH: acc = a[W/2-1:0]*b[W/2-1:0], c=0.
REQ-021 DIV: acc = a/b, c = a%b unsigned. DIVH: same on low W/2 bits, zero-extended.
REQ-022 Divide-by-zero SHALL complete in one cycle: acc = all ones, c = a, err=1, z_flag=0.
REQ-023 MUL/DIV families: z_flag = (acc==0); c_flag, o_flag = 0.
REQ-024 CMP unsigned: equal -> z=1,c=0,o=0; a<b -> z=0,c=1,o=0; a>b -> z=0,c=0,o=1; acc, c unchanged.
REQ-025 AND/OR/XOR bitwise; NEG acc=~a; NOT acc = (a==0)?1:0; z_flag=(acc==0); c_flag, o_flag=0.
REQ-026 SHL/SHR by one, zero fill; c_flag = bit shifted out; z_flag=(acc==0); o_flag=0.
REQ-027 TEST: z_flag = ((a&b)==0); other outputs unchanged.
REQ-028 Illegal opcode (00, >=12): err=1, done pulses next cycle, all other outputs unchanged.
REQ-029 err SHALL be cleared by every legal, non-faulting completion.
REQ-030 Outputs SHALL hold last values between completions.

Reset
REQ-031 rst_n=0 at a clk edge SHALL force IDLE, busy=0, done=0, acc=0, c=0, all flags=0, err=0, including mid-iteration; aborted op produces no done.
REQ-032 start during rst_n=0 SHALL be ignored.

Configuration
REQ-033 Macro DALU_MC_DIV_EN: defined -> iterative divider and DIV/DIVH per REQ-021/022; undefined -> no divider logic, DIV/DIVH treated as illegal opcodes per REQ-028.

Verification
REQ-034 W=16, ADD a=7FFF b=0001 -> next cycle done=1, acc=8000, c_flag=0, o_flag=1, z_flag=0.
REQ-035 MUL a=FFFF b=FFFF -> busy high 16 cycles, then done=1, c=FFFE, acc=0001; start asserted in done cycle with ADC a=1 b=1 cf=1 -> acc=0003.
REQ-036 DIV a=0064 b=0007 (DIV_EN defined) -> after 16 busy cycles acc=000E, c=0002, err=0; DIV b=0 -> next cycle acc=FFFF, c=0064, err=1.
REQ-037 CMP a=0003 b=0005 -> c_flag=1, z=0, o=0; SHL a=8001 -> acc=0002, c_flag=1; op=0x20 -> err=1, acc unchanged.
REQ-038 rst_n=0 at iteration 5 of MUL -> next cycle busy=0, acc=0, c=0, no done; following ADD accepted normally.
